// File: rtl/i2c_target_if_if.sv
// Bus and fabric signals of the I2C target, grouped so the target and its
// environment connect through one port.
interface i2c_target_if_if;
  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       busy;

  modport master (
    output scl,
    output sda_in,
    output tx_data,
    input  sda_oe,
    input  rx_data,
    input  rx_valid,
    input  tx_load,
    input  busy
  );

  modport slave (
    input  scl,
    input  sda_in,
    input  tx_data,
    output sda_oe,
    output rx_data,
    output rx_valid,
    output tx_load,
    output busy
  );
endinterface

// File: rtl/i2c_target_if.sv
// I2C target: oversamples SCL/SDA on clk, decodes START/STOP, matches a 7-bit
// address, receives write bytes and shifts out read bytes. Never stretches SCL.
module i2c_target_if #(
  parameter logic [6:0] TARGET_ADDR = 7'h2A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  i2c_target_if_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] shift_reg;
  logic [6:0] tx_shift;
  logic [7:0] rx_byte;
  logic       rw;
  logic       byte_done;
  logic       sda_oe_r;
  logic [7:0] rx_data_r;
  logic       rx_valid_r;
  logic       tx_load_r;
  logic       busy_r;

  // Synchronizers idle high so reset never looks like a START or an SCL edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;
  assign rx_byte   = {shift_reg, sda_s};

  // byte_done marks a completed 8th bit whose ACK slot opens at the next scl_fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift_reg  <= 7'd0;
      tx_shift   <= 7'd0;
      rw         <= 1'b0;
      byte_done  <= 1'b0;
      sda_oe_r   <= 1'b0;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      tx_load_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      tx_load_r  <= 1'b0;
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 3'd7;
        sda_oe_r  <= 1'b0;
        busy_r    <= 1'b0;
        byte_done <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        sda_oe_r  <= 1'b0;
        busy_r    <= 1'b0;
        byte_done <= 1'b0;
      end else begin
        unique case (state)
          IDLE, WAIT_STOP: begin
            sda_oe_r <= 1'b0;
          end

          ADDR: begin
            if (scl_rise && !byte_done) begin
              shift_reg <= rx_byte[6:0];
              if (bit_cnt == 3'd0) begin
                rw <= sda_s;
                if (shift_reg == TARGET_ADDR) begin
                  byte_done <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                end
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              sda_oe_r  <= 1'b1;
              busy_r    <= 1'b1;
              state     <= ADDR_ACK;
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd7;
              if (rw) begin
                tx_shift  <= bus.tx_data[6:0];
                tx_load_r <= 1'b1;
                sda_oe_r  <= ~bus.tx_data[7];
                state     <= TX;
              end else begin
                sda_oe_r <= 1'b0;
                state    <= RX;
              end
            end
          end

          RX: begin
            if (scl_rise && !byte_done) begin
              shift_reg <= rx_byte[6:0];
              if (bit_cnt == 3'd0) begin
                rx_data_r  <= rx_byte;
                rx_valid_r <= 1'b1;
                byte_done  <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              sda_oe_r  <= 1'b1;
              state     <= RX_ACK;
            end
          end

          RX_ACK: begin
            if (scl_fall) begin
              sda_oe_r <= 1'b0;
              bit_cnt  <= 3'd7;
              state    <= RX;
            end
          end

          // bit_cnt tracks the bit currently on the line; bit 7 went out on entry.
          TX: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe_r <= 1'b0;
                state    <= TX_ACK;
              end else begin
                sda_oe_r <= ~tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
                bit_cnt  <= bit_cnt - 3'd1;
              end
            end
          end

          TX_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                state <= WAIT_STOP;
              end else begin
                byte_done <= 1'b1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              bit_cnt   <= 3'd7;
              tx_shift  <= bus.tx_data[6:0];
              tx_load_r <= 1'b1;
              sda_oe_r  <= ~bus.tx_data[7];
              state     <= TX;
            end
          end
        endcase
      end
    end
  end

  assign bus.sda_oe   = sda_oe_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.tx_load  = tx_load_r;
  assign bus.busy     = busy_r;

endmodule
